// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence link (transmitter and detector side).
// Latency: n/a (types, constants and a constant helper function only).
// Backpressure: n/a.
package seq_pkg;

  // FSM encodings shared with the detector side so waveforms read the same.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Default sync pattern; the detector looks for this same sequence.
  localparam int                    SYNC_W_DEF   = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1011;

  // Largest of three phase lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register; MSB is presented first, zero fill.
// Latency: q_msb shows d[W-1] the cycle after load; each shift exposes the next bit.
// Backpressure: none; the owner decides when to load and when to shift.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] sr;

  // Load takes priority over shift; shifting left pulls zeros in at the LSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign q_msb = sr[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then idle zero gap.
// Latency: first sync bit on tx_bit the cycle after the accept edge; frame = SYNC_W+DATA_W+GAP.
// Backpressure: data_ready only in IDLE or the last gap cycle, so frames can run back to back.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                GAP      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // state/cnt describe the bit currently on tx_bit; the *_n values describe
  // the bit that will be driven after the next edge.
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept;
  logic              pay_load, pay_shift, pay_msb;
  logic              tx_bit_n, tx_active_n, frame_done_n;
  logic [SYNC_W-1:0] sync_shifted;

  // Ready is a pure function of the current phase so upstream sees it early.
  assign data_ready = (state == ST_IDLE) || ((state == ST_GAP) && (cnt == GAP_LAST));
  assign accept     = data_valid && data_ready;

  // Payload is latched on accept and shifted once per bit as it is driven out.
  assign pay_load  = accept;
  assign pay_shift = (state_n == ST_DATA);

  piso_shift #(
    .W(DATA_W)
  ) u_payload (
    .clk   (clk),
    .reset (reset),
    .load  (pay_load),
    .shift (pay_shift),
    .d     (data_in),
    .q_msb (pay_msb)
  );

  // Sync bit for the next cycle: shift the pattern so the wanted bit lands at the MSB.
  assign sync_shifted = SYNC_PAT << cnt_n;

  // State and shared phase counter; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next phase: counter runs up to the phase terminal value, then restarts at zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_SYNC;
          cnt_n   = '0;
        end
      end
      ST_SYNC: begin
        if (cnt == SYNC_LAST) begin
          state_n = ST_DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt == DATA_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = accept ? ST_SYNC : ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output values for the phase being entered; registered below so tx_bit is glitch-free.
  always_comb begin
    tx_bit_n     = 1'b0;
    tx_active_n  = 1'b0;
    frame_done_n = 1'b0;
    unique case (state_n)
      ST_SYNC: begin
        tx_bit_n    = sync_shifted[SYNC_W-1];
        tx_active_n = 1'b1;
      end
      ST_DATA: begin
        tx_bit_n     = pay_msb;
        tx_active_n  = 1'b1;
        frame_done_n = (cnt_n == DATA_LAST);
      end
      default: begin
        tx_bit_n     = 1'b0;
        tx_active_n  = 1'b0;
        frame_done_n = 1'b0;
      end
    endcase
  end

  // Registered serial outputs; reset forces the line idle on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_bit     <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_bit     <= tx_bit_n;
      tx_active  <= tx_active_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
